label_vote_classifier: RTL
==========================

LABEL_VOTE_CLASSIFIER -- requirements
Module: label_vote_classifier

Interface
REQ-001 SHALL have parameter bitlength, default 12: width of each packed unit field on LayerData and of class_out.
REQ-002 SHALL have parameter label_dim, default 10: number of label units produced by the upstream output layer.
REQ-003 SHALL have parameter vote_rounds, default 8: number of sampling passes accumulated per classification (legal range 1..255).
REQ-004 SHALL have parameter count_bitlength, default 8: width of each per-label vote counter.
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a classification.
REQ-008 SHALL have port layer_finish  input  1  level "layer outputs complete" from the upstream layer.
REQ-009 SHALL have port LayerData  input  label_dim*bitlength  packed layer outputs; field k = bits [k*bitlength +: bitlength]; unit k fires when bit 0 of field k is 1.
REQ-010 SHALL have port layer_restart  output  1  one-cycle active-high pulse that resets and re-runs the upstream layer.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port class_out  output  bitlength  winning label index, zero-extended.
REQ-013 SHALL have port no_vote  output  1  high when every counter was zero at the end of the scan.
REQ-014 SHALL have port class_valid  output  1  one-cycle pulse when class_out and no_vote are updated.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT, ACCUM, RESTART, SCAN and DONE.
REQ-016 IDLE: on start=1, SHALL clear all counters, round=0 and scan index=0, then enter WAIT on the next edge; when not in IDLE, start SHALL be ignored.
REQ-017 WAIT: SHALL stay while layer_finish=0 and enter ACCUM on the first edge with layer_finish=1, registering LayerData on that same edge.
REQ-018 ACCUM (one cycle): for each k with registered bit 0 of field k =1, SHALL increment counter k by 1, saturating at 2^count_bitlength-1; SHALL increment round by 1.
REQ-019 ACCUM exit: if the incremented round equals vote_rounds, SHALL go to SCAN; otherwise SHALL go to RESTART.
REQ-020 RESTART (one cycle): layer_restart SHALL be 1 in this state only; next state SHALL be WAIT.
REQ-021 layer_finish SHALL be ignored during RESTART and during the first WAIT cycle after RESTART, so a stale finish level is never re-sampled.
REQ-022 SCAN: SHALL compare one counter per cycle for indices 0..label_dim-1, i.e. label_dim cycles.
REQ-023 SCAN best-tracking: best starts at index 0; index k SHALL replace best only if count[k] > count[best] (strictly greater), so ties resolve to the lowest index.
REQ-024 SCAN exit: after index label_dim-1 SHALL go to DONE.
REQ-025 DONE (one cycle): class_out SHALL load best, no_vote SHALL load (max count == 0), class_valid=1; next state SHALL be IDLE.
REQ-026 class_out and no_vote SHALL hold their values until the next DONE or reset.
REQ-027 Latency: the DONE cycle SHALL be exactly label_dim+1 cycles after the final ACCUM cycle.
REQ-028 Counters and round SHALL be unsigned; count_bitlength SHALL be at least ceil(log2(vote_rounds+1)), so saturation never occurs at default parameters.

Reset
REQ-029 reset=0 SHALL, asynchronously, force state IDLE, zero all counters, round and scan index, and drive layer_restart=0, busy=0, class_out=0, no_vote=0, class_valid=0.
REQ-030 reset asserted mid-classification (any state) SHALL abandon it with no class_valid pulse; a new start after reset release SHALL begin cleanly.
REQ-031 Release of reset SHALL take effect at the next clock edge.

Verification
REQ-032 vote_rounds=1, start, layer_finish=1 with only unit 3 firing -> 0 restart pulses, class_valid 11 cycles after ACCUM, class_out=3, no_vote=0.
REQ-033 Default parameters; unit 7 fires in all 8 passes, unit 2 in 5 passes -> exactly 7 layer_restart pulses, class_out=7, counts 8 and 5.
REQ-034 Tie: units 4 and 6 each fire in 8 of 8 passes -> class_out=4.
REQ-035 No unit fires in any pass -> class_out=0, no_vote=1, class_valid exactly one cycle.
REQ-036 Hold layer_finish=1 continuously -> exactly one ACCUM per RESTART; start pulsed while busy is ignored; reset=0 during SCAN -> all outputs 0 immediately, no class_valid.

Source files
------------

// File: rtl/label_vote_classifier.sv
// Label vote classifier: accumulates per-label fire counts over several upstream
// layer passes, then scans the counters for the most-voted label.
module label_vote_classifier #(
  parameter int bitlength       = 12,
  parameter int label_dim       = 10,
  parameter int vote_rounds     = 8,
  parameter int count_bitlength = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           layer_finish,
  input  logic [label_dim*bitlength-1:0] LayerData,
  output logic                           layer_restart,
  output logic                           busy,
  output logic [bitlength-1:0]           class_out,
  output logic                           no_vote,
  output logic                           class_valid,
  output logic [2:0]                     state_dbg
);

  localparam int IdxW = (label_dim > 1) ? $clog2(label_dim) : 1;
  localparam logic [7:0] RoundsLast = 8'(vote_rounds);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(label_dim - 1);
  localparam logic [count_bitlength-1:0] CntMax = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ACCUM   = 3'd2,
    S_RESTART = 3'd3,
    S_SCAN    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [count_bitlength-1:0] count_q [label_dim];
  logic [count_bitlength-1:0] count_d [label_dim];
  logic [7:0]                 round_q, round_d, round_inc;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [IdxW-1:0]            best_q, best_d;
  logic [label_dim-1:0]       fire_q, fire_d;
  logic                       skip_q, skip_d;
  logic [bitlength-1:0]       class_q, class_d;
  logic                       no_vote_q, no_vote_d;

  // Only bit 0 of each field is a vote; the remaining field bits are don't-care.
  logic unused_layer_bits;
  assign unused_layer_bits = ^LayerData;

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    idx_d     = idx_q;
    best_d    = best_q;
    fire_d    = fire_q;
    skip_d    = skip_q;
    class_d   = class_q;
    no_vote_d = no_vote_q;
    round_inc = round_q + 8'd1;
    for (int k = 0; k < label_dim; k++) begin
      count_d[k] = count_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < label_dim; k++) begin
            count_d[k] = '0;
          end
          round_d = '0;
          idx_d   = '0;
          best_d  = '0;
          skip_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // skip_q masks the first WAIT cycle after a restart, when the upstream
        // finish level may still be the stale one from the previous pass.
        skip_d = 1'b0;
        if (layer_finish && !skip_q) begin
          for (int k = 0; k < label_dim; k++) begin
            fire_d[k] = LayerData[k*bitlength];
          end
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        for (int k = 0; k < label_dim; k++) begin
          if (fire_q[k] && (count_q[k] != CntMax)) begin
            count_d[k] = count_q[k] + count_bitlength'(1);
          end
        end
        round_d = round_inc;
        idx_d   = '0;
        best_d  = '0;
        state_d = (round_inc == RoundsLast) ? S_SCAN : S_RESTART;
      end
      S_RESTART: begin
        skip_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_SCAN: begin
        if (count_q[idx_q] > count_q[best_q]) begin
          best_d = idx_q;
        end
        // Result registers load on the edge into DONE so they are valid while
        // class_valid is high.
        if (idx_q == IdxLast) begin
          class_d   = bitlength'(best_d);
          no_vote_d = (count_q[best_d] == '0);
          state_d   = S_DONE;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      round_q   <= '0;
      idx_q     <= '0;
      best_q    <= '0;
      fire_q    <= '0;
      skip_q    <= 1'b0;
      class_q   <= '0;
      no_vote_q <= 1'b0;
      for (int k = 0; k < label_dim; k++) begin
        count_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      fire_q    <= fire_d;
      skip_q    <= skip_d;
      class_q   <= class_d;
      no_vote_q <= no_vote_d;
      for (int k = 0; k < label_dim; k++) begin
        count_q[k] <= count_d[k];
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign layer_restart = (state_q == S_RESTART);
  assign class_valid   = (state_q == S_DONE);
  assign class_out     = class_q;
  assign no_vote       = no_vote_q;
  assign state_dbg     = state_q;

endmodule
